// File: rtl/rv_imm_gen_pipe.sv
// rv_imm_gen_pipe
//   Pipelined RISC-V immediate generator for the decode stage. It works out the
//   immediate format (I/S/B/U/J) from the opcode of a 32-bit instruction. It then
//   builds the immediate and sign-extends it to DATA_WIDTH. The result sits in a
//   main register with a skid register behind it, so the valid/ready handshake
//   keeps full throughput under backpressure. A saturating counter tracks
//   accepted instructions that have no recognised immediate format.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush; empties main and skid registers
//   instr_i      instruction word; valid_i qualifies it
//   ready_o      block can accept (skid register empty)
//   imm_o        sign-extended immediate of the head entry
//   fmt_o        0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; valid_o qualifies it
//   ready_i      downstream accepts the head entry
//   unsup_cnt_o  saturating count of accepted NONE-format instructions
module rv_imm_gen_pipe #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [31:0]           instr_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [2:0]            fmt_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  unsup_cnt_o
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // Decode of the incoming instruction
    fmt_e                  fmt_dec;
    logic [31:0]           raw_dec;
    logic [DATA_WIDTH-1:0] imm_dec;

    // Storage
    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_imm_q,   main_imm_d;
    fmt_e                  main_fmt_q,   main_fmt_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_imm_q,   skid_imm_d;
    fmt_e                  skid_fmt_q,   skid_fmt_d;
    logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;

    logic in_fire;
    logic out_fire;

    always_comb begin
        fmt_dec = FMT_NONE;
        raw_dec = '0;
        case (instr_i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                fmt_dec = FMT_I;
                raw_dec = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            7'b0100011: begin
                fmt_dec = FMT_S;
                raw_dec = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'b1100011: begin
                fmt_dec = FMT_B;
                raw_dec = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_dec = FMT_U;
                raw_dec = {instr_i[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_dec = FMT_J;
                raw_dec = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            default: begin
                fmt_dec = FMT_NONE;
                raw_dec = '0;
            end
        endcase
    end

    // raw_dec is already sign-extended to 32 bits; widen (or keep) to DATA_WIDTH
    always_comb begin
        imm_dec = '0;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            imm_dec[b] = (b < 32) ? raw_dec[b[4:0]] : raw_dec[31];
        end
    end

    assign ready_o  = !skid_valid_q;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = main_valid_q && ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        cnt_d        = cnt_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // ready_o is low, so nothing can enter; only the skid can advance
            if (out_fire) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_fmt_d   = skid_fmt_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || ready_i) begin
                main_valid_d = 1'b1;
                main_imm_d   = imm_dec;
                main_fmt_d   = fmt_dec;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = imm_dec;
                skid_fmt_d   = fmt_dec;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end

        if (in_fire && !flush_i && (fmt_dec == FMT_NONE) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_fmt_q   <= FMT_NONE;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign valid_o     = main_valid_q;
    assign imm_o       = main_imm_q;
    assign fmt_o       = main_fmt_q;
    assign unsup_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv_imm_gen_pipe.sv
// tb_rv_imm_gen_pipe
//   Drives two instances from the same stimulus: a 64-bit one with a 2-bit
//   counter, so saturation is reachable, and a 32-bit one with a 16-bit counter.
//   A queue-based reference model predicts every output cycle by cycle. Literal
//   checks on known encodings pin that model down.
module tb_rv_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] instr = '0;
    logic        vin = 1'b0;
    logic        rdy = 1'b0;

    logic        ready64, valid64, ready32, valid32;
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt64, fmt32;
    logic [1:0]  cnt64;
    logic [15:0] cnt32;

    int tests = 0;
    int failed = 0;

    // Model state: accepted, not yet delivered instructions in order
    logic [31:0] q[$];
    int unsigned m_cnt64 = 0;
    int unsigned m_cnt32 = 0;

    always #5 clk = ~clk;

    rv_imm_gen_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr),
        .valid_i(vin), .ready_o(ready64), .imm_o(imm64), .fmt_o(fmt64),
        .valid_o(valid64), .ready_i(rdy), .unsup_cnt_o(cnt64)
    );

    rv_imm_gen_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr),
        .valid_i(vin), .ready_o(ready32), .imm_o(imm32), .fmt_o(fmt32),
        .valid_o(valid32), .ready_i(rdy), .unsup_cnt_o(cnt32)
    );

    function automatic int ref_fmt(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        case (op)
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic longint ref_imm(input logic [31:0] ins);
        logic signed [11:0] i_imm;
        logic signed [12:0] b_imm;
        logic signed [31:0] u_imm;
        logic signed [20:0] j_imm;
        i_imm = ins[31:20];
        case (ref_fmt(ins))
            1: return longint'(i_imm);
            2: begin
                i_imm = {ins[31:25], ins[11:7]};
                return longint'(i_imm);
            end
            3: begin
                b_imm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                return longint'(b_imm);
            end
            4: begin
                u_imm = {ins[31:12], 12'h000};
                return longint'(u_imm);
            end
            5: begin
                j_imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                return longint'(j_imm);
            end
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare both DUTs against the model state
    task automatic compare();
        logic [63:0] e64;
        logic [31:0] e32;
        logic        ev;
        ev = (q.size() != 0);
        chk("valid64", 64'(valid64), 64'(ev));
        chk("valid32", 64'(valid32), 64'(ev));
        chk("ready64", 64'(ready64), 64'(q.size() < 2));
        chk("ready32", 64'(ready32), 64'(q.size() < 2));
        if (ev) begin
            e64 = ref_imm(q[0]);
            e32 = e64[31:0];
            chk("imm64", imm64, e64);
            chk("imm32", 64'(imm32), 64'(e32));
            chk("fmt64", 64'(fmt64), 64'(ref_fmt(q[0])));
            chk("fmt32", 64'(fmt32), 64'(ref_fmt(q[0])));
        end
        chk("cnt64", 64'(cnt64), 64'(m_cnt64));
        chk("cnt32", 64'(cnt32), 64'(m_cnt32));
    endtask

    // One clock: drive inputs, advance model, let edge happen, compare
    task automatic step(input logic v, input logic [31:0] ins, input logic r,
                        input logic f, input logic rs);
        logic in_f, out_f;
        vin = v; instr = ins; rdy = r; flush = f; rst = rs;
        if (rs) begin
            q.delete();
            m_cnt64 = 0;
            m_cnt32 = 0;
        end else begin
            in_f  = v && (q.size() < 2);
            out_f = (q.size() != 0) && r;
            if (f) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) begin
                    q.push_back(ins);
                    if (ref_fmt(ins) == 0) begin
                        if (m_cnt64 < 3) m_cnt64++;
                        if (m_cnt32 < 65535) m_cnt32++;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    logic [6:0] op_tab[11] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(valid64), 64'd0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_fmt", 64'(fmt64), 64'd0);
        chk("rst_ready", 64'(ready64), 64'd1);
        chk("rst_cnt", 64'(cnt64), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single transfers, one-cycle latency
        step(1, 32'hFFF00093, 1, 0, 0);
        chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
        chk("addi_fmt", 64'(fmt64), 64'd1);
        step(1, 32'h00112623, 1, 0, 0);
        chk("sw_imm64", imm64, 64'd12);
        chk("sw_fmt", 64'(fmt64), 64'd2);
        step(1, 32'hFFDFF06F, 1, 0, 0);
        chk("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_imm32", 64'(imm32), 64'hFFFF_FFFC);
        chk("jal_fmt", 64'(fmt64), 64'd5);
        step(1, 32'h123450B7, 1, 0, 0);
        chk("lui_imm64", imm64, 64'h0000_0000_1234_5000);
        chk("lui_fmt", 64'(fmt64), 64'd4);
        step(1, 32'h800000B7, 1, 0, 0);
        chk("luineg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("luineg_imm32", 64'(imm32), 64'h8000_0000);
        step(0, 32'h0, 1, 0, 0);

        // Backpressure: A then B stalled, then drained in order
        step(1, 32'h00112623, 0, 0, 0);
        step(1, 32'hFFDFF06F, 0, 0, 0);
        chk("bp_ready_low", 64'(ready64), 64'd0);
        chk("bp_hold_a", imm64, 64'd12);
        step(0, 32'h0, 0, 0, 0);
        chk("bp_still_a", imm64, 64'd12);
        step(0, 32'h0, 1, 0, 0);
        chk("bp_then_b", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("bp_ready_back", 64'(ready64), 64'd1);
        step(0, 32'h0, 1, 0, 0);
        chk("bp_empty", 64'(valid64), 64'd0);

        // Unsupported opcode counting and saturation of the 2-bit counter
        step(1, 32'h00000033, 1, 0, 0);
        chk("add_fmt", 64'(fmt64), 64'd0);
        chk("add_imm", imm64, 64'd0);
        chk("cnt_1", 64'(cnt64), 64'd1);
        step(1, 32'h00000033, 1, 0, 0);
        chk("cnt_2", 64'(cnt64), 64'd2);
        step(1, 32'h00000033, 1, 0, 0);
        chk("cnt_3", 64'(cnt64), 64'd3);
        step(1, 32'h00000033, 1, 0, 0);
        chk("cnt_sat", 64'(cnt64), 64'd3);
        chk("cnt32_4", 64'(cnt32), 64'd4);
        step(0, 32'h0, 1, 0, 0);

        // Flush with both registers full
        step(1, 32'hFFF00093, 0, 0, 0);
        step(1, 32'h00112623, 0, 0, 0);
        step(1, 32'h00000033, 0, 1, 0);
        chk("flush_full_valid", 64'(valid64), 64'd0);
        // Flush dominates a same-cycle accept of a NONE instruction
        step(1, 32'hFFF00093, 0, 0, 0);
        step(1, 32'h00000033, 0, 1, 0);
        chk("flush_acc_valid", 64'(valid64), 64'd0);
        chk("flush_acc_cnt32", 64'(cnt32), 64'd4);

        // Reset with both registers full and an accept pending
        step(1, 32'hFFF00093, 0, 0, 0);
        step(1, 32'h00112623, 0, 0, 0);
        step(1, 32'h00000033, 1, 0, 1);
        chk("rst_mid_valid", 64'(valid64), 64'd0);
        chk("rst_mid_cnt32", 64'(cnt32), 64'd0);
        chk("rst_mid_imm", imm64, 64'd0);
        step(0, 32'h0, 0, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            r  = $urandom;
            op = op_tab[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) op = r[6:0];
            step(($urandom_range(0, 9) < 7), {r[31:7], op},
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
